// File: rtl/td4_pkg.sv
// td4_pkg: shared constants and the program-loader state type for the
// TD4 writable program store.
//   ADR_W / DATA_W / DEPTH : instruction memory geometry (DEPTH == 2**ADR_W)
//   LOAD_HDR               : byte that opens a load frame
//   load_state_e           : loader FSM states
package td4_pkg;

  localparam int ADR_W  = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  localparam logic [7:0] LOAD_HDR = 8'hA5;

  typedef enum logic [2:0] {
    WAIT_HDR = 3'd0,
    LOAD     = 3'd1,
    CHECK    = 3'd2,
    DONE     = 3'd3,
    RUN      = 3'd4,
    ERR      = 3'd5
  } load_state_e;

endpackage

// File: rtl/td4_prog_mem.sv
// td4_prog_mem: DEPTH x DATA_W instruction register file.
//   clk      : rising-edge clock
//   reset    : asynchronous active-low clear of every word
//   we/wa/wd : synchronous write port
//   rom_adr  : combinational read address (CPU side)
//   rom_data : word at rom_adr, same cycle
module td4_prog_mem #(
  parameter int ADR_W  = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADR_W-1:0]  wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADR_W-1:0]  rom_adr,
  output logic [DATA_W-1:0] rom_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rom_data = mem[rom_adr];

endmodule

// File: rtl/td4_prog_loader.sv
// td4_prog_loader: writable program store for the TD4 core. Accepts a frame
// (header, DEPTH instruction bytes, 8-bit additive checksum) and releases
// the CPU from reset only after a frame with a matching checksum.
//   clk, reset          : clock, asynchronous active-low reset
//   in_data/in_valid    : load stream byte and its valid
//   in_ready            : loader can take a byte this cycle
//   rom_adr/rom_data    : CPU instruction fetch (combinational)
//   cpu_reset           : active-high reset to the core (low only in RUN)
//   loaded              : one-cycle pulse after a good frame
//   load_err            : level, last frame failed its checksum
//   state_dbg           : current loader state
//
// Handshake: a byte transfers on the rising edge where in_valid && in_ready
// are both high. The source holds in_data/in_valid until that edge; in_ready
// does not depend on in_valid.
module td4_prog_loader #(
  parameter int         ADR_W    = td4_pkg::ADR_W,
  parameter int         DATA_W   = td4_pkg::DATA_W,
  parameter int         DEPTH    = td4_pkg::DEPTH,
  parameter logic [7:0] LOAD_HDR = td4_pkg::LOAD_HDR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADR_W-1:0]      rom_adr,
  output logic [DATA_W-1:0]     rom_data,
  output logic                  cpu_reset,
  output logic                  loaded,
  output logic                  load_err,
  output td4_pkg::load_state_e  state_dbg
);

  import td4_pkg::*;

  load_state_e      state, state_nxt;
  logic             ready_en;  // keeps in_ready low until the first edge out of reset
  logic             accept;
  logic             is_hdr;
  logic             mem_we;
  logic [ADR_W-1:0] cnt;
  logic [7:0]       sum;

  assign accept    = in_valid && in_ready;
  assign is_hdr    = (in_data == LOAD_HDR);
  assign state_dbg = state;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= WAIT_HDR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_HDR, ERR, RUN: begin
        if (accept && is_hdr) state_nxt = LOAD;
      end
      LOAD: begin
        if (accept && cnt == ADR_W'(DEPTH - 1)) state_nxt = CHECK;
      end
      CHECK: begin
        if (accept) state_nxt = (in_data == sum) ? DONE : ERR;
      end
      DONE:    state_nxt = RUN;
      default: state_nxt = WAIT_HDR;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = ready_en && (state != DONE);
    cpu_reset = (state != RUN);
    loaded    = (state == DONE);
    mem_we    = in_valid && in_ready && (state == LOAD);
  end

  // Address counter, running checksum, error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      load_err <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        unique case (state)
          WAIT_HDR, ERR, RUN: begin
            if (is_hdr) begin
              cnt      <= '0;
              sum      <= '0;
              load_err <= 1'b0;
            end
          end
          LOAD: begin
            cnt <= cnt + ADR_W'(1);
            sum <= sum + in_data;
          end
          CHECK: begin
            if (in_data != sum) load_err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  td4_prog_mem #(
    .ADR_W  (ADR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk      (clk),
    .reset    (reset),
    .we       (mem_we),
    .wa       (cnt),
    .wd       (DATA_W'(in_data)),
    .rom_adr  (rom_adr),
    .rom_data (rom_data)
  );

endmodule

// File: tb/tb_td4_prog_loader.sv
module tb_td4_prog_loader;

  import td4_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]        in_data  = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADR_W-1:0]  rom_adr  = '0;
  logic [DATA_W-1:0] rom_data;
  logic              cpu_reset;
  logic              loaded;
  logic              load_err;
  load_state_e       state_dbg;

  td4_prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rom_adr   (rom_adr),
    .rom_data  (rom_data),
    .cpu_reset (cpu_reset),
    .loaded    (loaded),
    .load_err  (load_err),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard / reference ----------------
  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] exp_q[$];         // checksums of frames that must produce a loaded pulse
  logic [7:0] model_mem [16];   // expected instruction image
  logic [7:0] frame_d [16];     // data bytes of the frame being sent
  logic [7:0] last_ck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Every loaded pulse must match a good frame the model predicted.
  always @(negedge clk) begin
    if (loaded) begin
      if (exp_q.size() == 0) check("loaded_unexpected", 1, 0);
      else check("loaded_frame_ck", last_ck, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 16; a++) begin
      rom_adr = ADR_W'(a);
      #1;
      check($sformatf("%s_rom[%0d]", tag, a), rom_data, model_mem[a]);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] ck,
                           input int min_gap, input int max_gap, input int garbage);
    logic [7:0] s;
    logic [7:0] gb;
    bit good;
    s = 8'h00;
    for (int i = 0; i < 16; i++) s = s + frame_d[i];
    good = (s == ck);
    for (int g = 0; g < garbage; g++) begin
      do gb = 8'($urandom_range(0, 255)); while (gb == LOAD_HDR);
      send_byte(gb);
    end
    send_byte(LOAD_HDR);
    @(negedge clk);
    check({tag, "_hdr_cpu_reset"}, cpu_reset, 1);
    check({tag, "_hdr_load_err"}, load_err, 0);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(min_gap, max_gap)) @(negedge clk);
      send_byte(frame_d[i]);
    end
    last_ck = ck;
    if (good) exp_q.push_back(ck);
    send_byte(ck);
    @(negedge clk);
    if (good) begin
      check({tag, "_done_loaded"}, loaded, 1);
      check({tag, "_done_in_ready"}, in_ready, 0);
      check({tag, "_done_cpu_reset"}, cpu_reset, 1);
      @(negedge clk);
      check({tag, "_run_cpu_reset"}, cpu_reset, 0);
      check({tag, "_run_loaded"}, loaded, 0);
      check({tag, "_run_in_ready"}, in_ready, 1);
      check({tag, "_run_load_err"}, load_err, 0);
    end else begin
      check({tag, "_err_load_err"}, load_err, 1);
      check({tag, "_err_loaded"}, loaded, 0);
      check({tag, "_err_cpu_reset"}, cpu_reset, 1);
      check({tag, "_err_in_ready"}, in_ready, 1);
      @(negedge clk);
      check({tag, "_err_hold_cpu_reset"}, cpu_reset, 1);
    end
    for (int i = 0; i < 16; i++) model_mem[i] = frame_d[i];
    check_mem(tag);
  endtask

  task automatic set_frame(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    for (int i = 0; i < 16; i++) frame_d[i] = 8'h00;
    frame_d[0] = b0;
    frame_d[1] = b1;
    frame_d[2] = b2;
    frame_d[3] = b3;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] s;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;

    // Reset then idle
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_loaded", loaded, 0);
    check("rst_load_err", load_err, 0);
    reset = 1'b1;
    #1;
    check("rst_rel_in_ready", in_ready, 0);
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_cpu_reset", cpu_reset, 1);
    check("idle_load_err", load_err, 0);
    check_mem("idle");

    // Good load
    set_frame(8'h3F, 8'h40, 8'h30, 8'h70);
    run_frame("good", 8'h1F, 0, 0, 0);

    // Bad checksum
    run_frame("badck", 8'h20, 0, 0, 0);

    // Garbage and 3-cycle gaps
    send_byte(8'h00);
    send_byte(8'h55);
    check("garb_cpu_reset", cpu_reset, 1);
    run_frame("gaps", 8'h1F, 3, 3, 0);

    // Reload while in RUN
    set_frame(8'h01, 8'hE0, 8'h51, 8'hF0);
    run_frame("reload", 8'h22, 0, 1, 0);

    // Reset mid-frame
    send_byte(LOAD_HDR);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(1, 255)));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_in_ready", in_ready, 0);
    check("mid_cpu_reset", cpu_reset, 1);
    check("mid_loaded", loaded, 0);
    check("mid_state", state_dbg, WAIT_HDR);
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    check_mem("mid");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rel_in_ready", in_ready, 1);
    set_frame(8'h3F, 8'h40, 8'h30, 8'h70);
    run_frame("after_mid", 8'h1F, 0, 0, 0);

    // Randomized frames, some with a corrupted checksum
    for (int f = 0; f < 8; f++) begin
      s = 8'h00;
      for (int i = 0; i < 16; i++) begin
        frame_d[i] = 8'($urandom_range(0, 255));
        s = s + frame_d[i];
      end
      if ($urandom_range(0, 1) == 1) s = s ^ 8'($urandom_range(1, 255));
      run_frame($sformatf("rnd%0d", f), s, 0, 2, $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
